// File: rtl/multicycle_right_shifter_pkg.sv
// Shared constants and FSM state encoding for the iterative right shifter.
// The stall controller imports the same state names.
package multicycle_right_shifter_pkg;

    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;
    localparam int STAGES  = SHAMT_W;
    localparam int K_W     = $clog2(STAGES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/multicycle_right_shifter_if.sv
// Start/busy/done handshake and operand/result bus of the right shifter.
interface multicycle_right_shifter_if;

    logic                                         start;
    logic [multicycle_right_shifter_pkg::WIDTH-1:0]   data_in;
    logic [multicycle_right_shifter_pkg::SHAMT_W-1:0] shamt;
    logic                                         arith;
    logic                                         busy;
    logic                                         done;
    logic [multicycle_right_shifter_pkg::WIDTH-1:0]   result;

    modport master (
        output start, data_in, shamt, arith,
        input  busy, done, result
    );

    modport slave (
        input  start, data_in, shamt, arith,
        output busy, done, result
    );

endinterface

// File: rtl/multicycle_right_shifter_sr_stage.sv
// One power-of-two right-shift stage: shifts by 2**amt_sel when enabled,
// filling the vacated upper bits with the supplied fill bit.
module sr_stage
    import multicycle_right_shifter_pkg::*;
(
    input  logic [WIDTH-1:0] stage_in,
    input  logic [K_W-1:0]   amt_sel,
    input  logic             en,
    input  logic             fill,
    output logic [WIDTH-1:0] stage_out
);

    logic [SHAMT_W-1:0] amount;
    logic [WIDTH-1:0]   shifted;
    logic [WIDTH-1:0]   fill_mask;

    // The mask marks the vacated upper bits so zero and sign fill share one path.
    always_comb begin
        amount    = SHAMT_W'(1) << amt_sel;
        shifted   = stage_in >> amount;
        fill_mask = ~({WIDTH{1'b1}} >> amount);
        stage_out = en ? (shifted | (fill_mask & {WIDTH{fill}})) : stage_in;
    end

endmodule

// File: rtl/multicycle_right_shifter.sv
// Iterative SRL/SRA unit: one stage per cycle (16, 8, 4, 2, 1), fixed latency,
// start/busy/done handshake toward the multicycle stall logic.
module multicycle_right_shifter
    import multicycle_right_shifter_pkg::*;
(
    input  logic                        clock,
    input  logic                        reset,
    multicycle_right_shifter_if.slave   bus
);

    state_t             state;
    state_t             next_state;
    logic [WIDTH-1:0]   work;
    logic [SHAMT_W-1:0] shamt_q;
    logic               fill_q;
    logic [K_W-1:0]     k;
    logic [WIDTH-1:0]   result_q;
    logic [K_W-1:0]     stage_amt;
    logic               stage_en;
    logic [WIDTH-1:0]   stage_out;
    logic               last_stage;

    // Stage k handles shamt bit SHAMT_W-1-k, so the largest shift goes first.
    always_comb begin
        stage_amt  = K_W'(SHAMT_W - 1) - k;
        stage_en   = shamt_q[stage_amt];
        last_stage = (k == K_W'(STAGES - 1));
    end

    sr_stage u_stage (
        .stage_in  (work),
        .amt_sel   (stage_amt),
        .en        (stage_en),
        .fill      (fill_q),
        .stage_out (stage_out)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = bus.start ? SHIFT : IDLE;
            SHIFT:   next_state = last_stage ? DONE : SHIFT;
            DONE:    next_state = bus.start ? SHIFT : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        bus.busy   = (state == SHIFT);
        bus.done   = (state == DONE);
        bus.result = result_q;
    end

    // Fill bit comes from the captured operand's MSB, fixed for the whole operation.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            work     <= '0;
            shamt_q  <= '0;
            fill_q   <= 1'b0;
            k        <= '0;
            result_q <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        work    <= bus.data_in;
                        shamt_q <= bus.shamt;
                        fill_q  <= bus.arith & bus.data_in[WIDTH-1];
                        k       <= '0;
                    end
                end
                SHIFT: begin
                    work <= stage_out;
                    k    <= k + 1'b1;
                    if (last_stage) begin
                        result_q <= stage_out;
                    end
                end
                default: begin
                    k <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/multicycle_right_shifter.md
Name: multicycle_right_shifter

Overview:
Iterative logical/arithmetic right shifter for the processor's SRL/SRA path. It is the right-direction counterpart of the fixed left-shift stages. It applies one power-of-two stage per cycle (16, 8, 4, 2, 1), gated by the corresponding shamt bit. It sits beside the ALU and uses a start/busy/done handshake so the multicycle-op stall logic can wait on it.

Parameters:
WIDTH, 32, data width in bits
SHAMT_W, 5, shift-amount width; WIDTH must equal 2**SHAMT_W
STAGES, 5, number of shift cycles; equals SHAMT_W

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  request; sampled only when busy=0
data_in  input  WIDTH  operand to shift, captured on the accepted start
shamt  input  SHAMT_W  shift amount, captured on the accepted start
arith  input  1  1 = SRA (sign fill), 0 = SRL (zero fill); captured on the accepted start
busy  output  1  high while shifting
done  output  1  one-cycle pulse when result becomes valid
result  output  WIDTH  registered shifted value; held until the next completion

Behaviour:
- Reset (asynchronous, immediate): state=IDLE, busy=0, done=0, result=0, internal work/count/latched regs=0.
- States: IDLE, SHIFT, DONE.
- IDLE: busy=0, done=0. If start=1 at an edge: latch data_in, shamt and arith; clear stage counter k=0; go to SHIFT.
- SHIFT: busy=1, done=0. Each edge processes stage k with amount 2**(SHAMT_W-1-k), i.e. 16, 8, 4, 2, 1.
  - If latched shamt bit (SHAMT_W-1-k) is 1: work = work >> amount, filled with latched data_in MSB if arith=1, else 0.
  - If the bit is 0: work is unchanged.
  - k increments each edge.
  - On the edge processing k=STAGES-1: result <= final value; go to DONE.
- DONE: busy=0, done=1 for exactly one cycle.
  - start=1 at this edge is accepted as in IDLE (back-to-back); next state is SHIFT.
  - Otherwise the next state is IDLE.
- Latency: start sampled high at the edge ending cycle N. Cycles N+1..N+5 are SHIFT. Cycle N+6 is DONE, with done=1 and result valid. Latency is fixed and independent of shamt, including shamt=0.
- start while busy=1 is ignored. Inputs may change freely after capture without affecting the operation.
- The sign-fill bit is the MSB of the captured operand, not of the intermediate work value. These are equivalent, but the captured MSB is the reference for verification.
- result changes only on the completion edge or on reset. It is never partially updated.
- Reset mid-SHIFT aborts the operation: no done pulse, result=0.
- Arithmetic rules:
  - shamt=WIDTH-1 with arith=1 yields all copies of the sign bit.
  - With arith=0 it yields the MSB in bit 0.
  - No shamt value saturates or wraps; all 0..31 are legal.

Decomposition:
- Shared package: WIDTH and SHAMT_W constants, and the state enum (IDLE/SHIFT/DONE) as named localparams shared with the stall controller.
- One natural sub-module: sr_stage. It is combinational, with inputs in[WIDTH], amt_sel (stage index), en and fill. Output is in >> 2**amt when en=1, else in, with the vacated bits set to fill.
- The FSM, counter and registers live in the top module.

Test Plan:
1. SRL data_in=0x80000000, shamt=16, arith=0 -> result=0x00008000; done=1 only in cycle N+6; busy=1 in cycles N+1..N+5.
2. SRA data_in=0x80000000, shamt=16, arith=1 -> result=0xFFFF8000.
3. data_in=0xF0F01234, shamt=31: arith=1 -> 0xFFFFFFFF; arith=0 -> 0x00000001. Also 0x7FFFFFFF SRA 31 -> 0x00000000.
4. data_in=0x12345678, shamt=0 -> result=0x12345678 with the full 6-cycle latency. Also shamt=5, SRL -> 0x0091A2B3.
5. Handshake:
   - start pulsed during SHIFT with different operands -> ignored, original result delivered.
   - start held high in the DONE cycle -> second op accepted; its done arrives 6 cycles later.
6. reset asserted asynchronously mid-SHIFT (cycle N+3) -> busy=0, done=0, result=0 immediately with no done pulse; a following op (0x0000FF00 SRL 8 -> 0x000000FF) completes normally.
